// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states and access size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Access size in bytes; 0 marks a funct3 that has no load meaning.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_bytes = 3'd1;
      F3_H, F3_HU: size_bytes = 3'd2;
      F3_W:        size_bytes = 3'd4;
      default:     size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane/shift datapath: byte-lane mask over two words, store lane placement, load extraction and extension.
// Purely combinational; no handshake of its own.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [7:0]  lanes8_o,
  output logic [31:0] st_lo_o,
  output logic [31:0] st_hi_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  base;
  logic [4:0]  sh;
  logic [31:0] shifted;

  always_comb begin
    case (size_bytes(funct3_i))
      3'd1:    base = 8'h01;
      3'd2:    base = 8'h03;
      3'd4:    base = 8'h0F;
      default: base = 8'h00;
    endcase
  end

  assign sh       = {off_i, 3'b000};
  assign lanes8_o = base << off_i;
  assign st_lo_o  = wdata_i << sh;
  // A 32-bit shift at off=0 yields zero; that word is never enabled anyway.
  assign st_hi_o  = wdata_i >> (6'd32 - {1'b0, sh});
  assign shifted  = 32'({hi_i, lo_i} >> sh);

  always_comb begin
    case (funct3_i)
      F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ld_data_o = shifted;
      F3_BU:   ld_data_o = {24'h0, shifted[7:0]};
      F3_HU:   ld_data_o = {16'h0, shifted[15:0]};
      default: ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and dmem: one request per handshake, word-crossing accesses split in two.
// Latency 2 aligned / 3 crossing / 1 error; response held until resp_ready, req_ready only in IDLE.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DMEM_BYTES  = 128,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata
);

  state_t      state_q, state_d;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, lo_q, hi_q;
  logic        err_q;

  logic        accept;
  logic [2:0]  req_size;
  logic [32:0] req_last;
  logic        req_illegal, req_oor, req_cross, req_bad;
  logic [7:0]  lanes8;
  logic [31:0] st_lo, st_hi, ld_data, word0;

  assign req_ready   = (state_q == S_IDLE) && !rst;
  assign accept      = req_valid && req_ready;
  assign req_size    = size_bytes(req_funct3);
  assign req_illegal = req_store ? (req_funct3 > F3_W) : (req_size == 3'd0);
  // Range check is on the last byte touched, computed without 32-bit wrap.
  assign req_last    = {1'b0, req_addr} + {30'd0, req_size} - 33'd1;
  assign req_oor     = req_last >= 33'(DMEM_BYTES);
  assign req_cross   = ({2'b00, req_addr[1:0]} + {1'b0, req_size}) > 4'd4;
  assign req_bad     = req_illegal || req_oor || (req_cross && !MISALIGN_EN);

  lsu_align u_align (
    .funct3_i  (f3_q),
    .off_i     (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .lo_i      (lo_q),
    .hi_i      (hi_q),
    .lanes8_o  (lanes8),
    .st_lo_o   (st_lo),
    .st_hi_o   (st_hi),
    .ld_data_o (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = req_bad ? S_RESP : S_ACC0;
      S_ACC0:  state_d = (lanes8[7:4] != 4'h0) ? S_ACC1 : S_RESP;
      S_ACC1:  state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_bad;
        hi_q    <= 32'd0;
      end
      if (state_q == S_ACC0) lo_q <= drdata;
      if (state_q == S_ACC1) hi_q <= drdata;
    end
  end

  assign word0 = {addr_q[31:2], 2'b00};

  always_comb begin
    daddr      = 32'd0;
    dwdata     = 32'd0;
    we         = 4'h0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    case (state_q)
      S_ACC0: begin
        daddr  = word0;
        dwdata = st_lo;
        we     = store_q ? lanes8[3:0] : 4'h0;
      end
      S_ACC1: begin
        daddr  = word0 + 32'd4;
        dwdata = st_hi;
        we     = store_q ? lanes8[7:4] : 4'h0;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || store_q) ? 32'd0 : ld_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: byte-array reference memory, random traffic and directed corner cases.
module tb_load_store_unit;

  localparam int DMEM = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata, daddr, dwdata;
  logic [31:0] drdata;
  logic [3:0]  we;

  logic        m_req_valid = 1'b0, m_req_store = 1'b0, m_resp_ready = 1'b1;
  logic [2:0]  m_req_funct3 = 3'd0;
  logic [31:0] m_req_addr = 32'd0, m_req_wdata = 32'd0, m_drdata = 32'hA5A5_1234;
  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0] m_resp_rdata, m_daddr, m_dwdata;
  logic [3:0]  m_we;

  int nvec = 0, nfail = 0, cyc = 0;
  bit hold = 1'b0, init_now = 1'b1;
  logic [7:0] dmem [DMEM];
  logic [7:0] ref_mem [DMEM];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];
  logic [35:0] wlog[$];

  load_store_unit #(.DMEM_BYTES(DMEM), .MISALIGN_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .daddr(daddr),
    .dwdata(dwdata), .we(we), .drdata(drdata)
  );

  load_store_unit #(.DMEM_BYTES(DMEM), .MISALIGN_EN(1'b0)) u_dut_nomis (
    .clk(clk), .rst(rst), .req_valid(m_req_valid), .req_ready(m_req_ready), .req_store(m_req_store),
    .req_funct3(m_req_funct3), .req_addr(m_req_addr), .req_wdata(m_req_wdata), .resp_valid(m_resp_valid),
    .resp_ready(m_resp_ready), .resp_rdata(m_resp_rdata), .resp_err(m_resp_err), .daddr(m_daddr),
    .dwdata(m_dwdata), .we(m_we), .drdata(m_drdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    drdata = 32'h0;
    if (daddr < DMEM)
      for (int i = 0; i < 4; i++) drdata[8*i +: 8] = dmem[int'(daddr) + i];
  end

  always @(posedge clk) begin
    if (init_now) begin
      for (int i = 0; i < DMEM; i++) dmem[i] <= ref_mem[i];
    end else if (daddr < DMEM) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) dmem[int'(daddr) + i] <= dwdata[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    #1;
    resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Reference model: byte-granular memory, applies stores and predicts the response.
  function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd);
    exp_t e;
    int sz;
    longint last;
    logic [31:0] v;
    e.err = 1'b0; e.rdata = 32'h0; e.acc = 0; e.lat = 1;
    sz = 0;
    if (st) begin
      if (f3 == 3'd0) sz = 1; else if (f3 == 3'd1) sz = 2; else if (f3 == 3'd2) sz = 4;
    end else begin
      case (f3)
        3'd0, 3'd4: sz = 1;
        3'd1, 3'd5: sz = 2;
        3'd2:       sz = 4;
        default:    sz = 0;
      endcase
    end
    last = longint'({32'h0, a}) + sz - 1;
    if (sz == 0 || last >= DMEM) begin
      e.err = 1'b1;
      return e;
    end
    e.lat = (int'(a[1:0]) + sz > 4) ? 3 : 2;
    if (st) begin
      for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
      if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
      if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    e = model(st, f3, a, wd);
    e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
  endtask

  task automatic m_req(input logic [2:0] f3, input logic [31:0] a,
                       output logic err, output logic [31:0] rdata, output int lat);
    int n;
    @(negedge clk);
    m_req_valid = 1'b1; m_req_funct3 = f3; m_req_addr = a;
    n = 0;
    while (!m_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 m_req_valid = 1'b0;
    lat = 1;
    while (!m_resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    err = m_resp_err;
    rdata = m_resp_rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else begin
        if (we != 4'h0) begin
          wlog.push_back({daddr, we});
          if (daddr >= DMEM) chk("write_addr_range", daddr, 32'h0);
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'(resp_valid), 32'h0);
          end else begin
            e = exp_q[0];
            if (!seen) begin
              seen = 1'b1;
              chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("req_ready_in_resp", 32'(req_ready), 32'h0);
            if (resp_ready) begin
              void'(exp_q.pop_front());
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        m_err;
    logic [31:0] m_rdata, r_addr;
    int          m_lat, n;

    for (int i = 0; i < DMEM; i++) ref_mem[i] = 8'($urandom);

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_daddr", daddr, 32'h0);
    chk("rst_dwdata", dwdata, 32'h0);
    @(negedge clk);
    init_now = 1'b0;
    rst = 1'b0;
    #1 chk("idle_req_ready", 32'(req_ready), 32'h1);

    // Aligned word store then load back.
    wlog.delete();
    issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    drain();
    chk("sw_write_count", 32'(wlog.size()), 32'h1);
    if (wlog.size() > 0) begin
      chk("sw_daddr", wlog[0][35:4], 32'h10);
      chk("sw_we", 32'(wlog[0][3:0]), 32'hF);
    end
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    issue(1'b0, 3'd0, 32'h13, 32'h0);
    issue(1'b0, 3'd4, 32'h13, 32'h0);
    issue(1'b0, 3'd1, 32'h12, 32'h0);
    drain();

    // Word-crossing store splits into two lane-masked writes.
    wlog.delete();
    issue(1'b1, 3'd2, 32'h0E, 32'h1122_3344);
    drain();
    chk("split_write_count", 32'(wlog.size()), 32'h2);
    if (wlog.size() == 2) begin
      chk("split0_daddr", wlog[0][35:4], 32'h0C);
      chk("split0_we", 32'(wlog[0][3:0]), 32'hC);
      chk("split1_daddr", wlog[1][35:4], 32'h10);
      chk("split1_we", 32'(wlog[1][3:0]), 32'h3);
    end
    issue(1'b0, 3'd2, 32'h0E, 32'h0);
    drain();

    // Errors never touch memory.
    wlog.delete();
    issue(1'b0, 3'd2, 32'h7E, 32'h0);
    issue(1'b0, 3'd7, 32'h20, 32'h0);
    issue(1'b1, 3'd2, 32'h7E, 32'h0BAD_0BAD);
    issue(1'b1, 3'd4, 32'h20, 32'h0BAD_0BAD);
    issue(1'b1, 3'd2, 32'hFFFF_FFFE, 32'h0BAD_0BAD);
    drain();
    chk("err_write_count", 32'(wlog.size()), 32'h0);

    // Consumer stall holds the response.
    hold = 1'b1;
    issue(1'b0, 3'd1, 32'h11, 32'h0);
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    repeat (5) begin
      @(negedge clk);
      chk("hold_resp_valid", 32'(resp_valid), 32'h1);
    end
    hold = 1'b0;
    drain();
    issue(1'b0, 3'd4, 32'h11, 32'h0);
    drain();

    // Random traffic against the reference memory.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) r_addr = $urandom;
      else r_addr = 32'($urandom_range(0, DMEM + 3));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r_addr, $urandom);
    end
    drain();

    // Reset while the second half of a split store is on the bus.
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h1E; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (we !== 4'b0011 && n < 10) begin @(negedge clk); n++; end
    chk("acc1_we", 32'(we), 32'h3);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(we), 32'h0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("mid_rst_daddr", daddr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[30] = 8'h0D;
    ref_mem[31] = 8'hF0;
    #1 chk("post_rst_req_ready", 32'(req_ready), 32'h1);

    // Instance with splitting disabled.
    m_req(3'd1, 32'h03, m_err, m_rdata, m_lat);
    chk("nomis_lh3_err", 32'(m_err), 32'h1);
    chk("nomis_lh3_rdata", m_rdata, 32'h0);
    chk("nomis_lh3_lat", 32'(m_lat), 32'h1);
    m_req(3'd1, 32'h02, m_err, m_rdata, m_lat);
    chk("nomis_lh2_err", 32'(m_err), 32'h0);
    chk("nomis_lh2_rdata", m_rdata, 32'hFFFF_A5A5);
    chk("nomis_lh2_lat", 32'(m_lat), 32'h2);
    m_req(3'd2, 32'h05, m_err, m_rdata, m_lat);
    chk("nomis_lw5_err", 32'(m_err), 32'h1);

    for (int i = 0; i < DMEM; i++) chk($sformatf("mem[%0d]", i), 32'(dmem[i]), 32'(ref_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
